// File: rtl/screen_pkg.sv
// Shared definitions for the game-flow controller and the colour-select stage.
package screen_pkg;

  typedef enum logic [1:0] {
    SCR_START     = 2'b00,
    SCR_PLAY      = 2'b01,
    SCR_RED_WIN   = 2'b10,
    SCR_GREEN_WIN = 2'b11
  } screen_t;

  localparam logic [7:0] KEY_ENTER = 8'h28;

  typedef enum logic {
    EDGE_RISE = 1'b0,
    EDGE_FALL = 1'b1
  } edge_pol_t;

  // Counter width able to hold 0..max_val, never narrower than one bit.
  function automatic int hold_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/screen_fsm_edge_pulse.sv
// Single-cycle edge detector with a registered previous value and a
// configurable reset value for that register.
module edge_pulse
  import screen_pkg::*;
#(
  parameter edge_pol_t POLARITY  = EDGE_RISE,
  parameter logic      RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic pulse_o
);

  logic prev_q;

  // Remember last cycle's level of the monitored signal.
  always_ff @(posedge clk) begin
    if (reset) prev_q <= RESET_VAL;
    else       prev_q <= sig_i;
  end

  // Pulse is combinational from the current level and the stored one.
  always_comb begin
    if (POLARITY == EDGE_RISE) pulse_o = sig_i & ~prev_q;
    else                       pulse_o = ~sig_i & prev_q;
  end

endmodule

// File: rtl/screen_fsm.sv
// Game-flow controller: start screen -> play -> win screen -> start.
//
// state         | meaning
// --------------+----------------------------------------------------
// SCR_START     | title screen, waiting for a fresh START_KEY press
// SCR_PLAY      | round in progress, watching tank-hit events
// SCR_RED_WIN   | red won; hold for WIN_HOLD_FRAMES then accept key
// SCR_GREEN_WIN | green won; same hold behaviour as red
module screen_fsm
  import screen_pkg::*;
#(
  parameter logic [7:0] START_KEY       = KEY_ENTER,
  parameter int         WIN_HOLD_FRAMES = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  input  logic       red_hit,
  input  logic       green_hit,
  output logic [1:0] screen,
  output logic       game_reset,
  output logic       game_active
);

  localparam int HOLD_W = hold_width(WIN_HOLD_FRAMES);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(WIN_HOLD_FRAMES);

  screen_t           state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              game_reset_q, game_reset_d;
  logic              game_active_q, game_active_d;
  logic              key_now, key_edge, frame_tick;

  assign key_now = (keycode == START_KEY);

  edge_pulse #(.POLARITY(EDGE_RISE), .RESET_VAL(1'b0)) u_key_edge (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (key_now),
    .pulse_o (key_edge)
  );

  // vs idles high, so the previous value resets to 1 to avoid a false tick.
  edge_pulse #(.POLARITY(EDGE_FALL), .RESET_VAL(1'b1)) u_frame_tick (
    .clk     (clk),
    .reset   (reset),
    .sig_i   (vs),
    .pulse_o (frame_tick)
  );

  // State, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SCR_START;
      hold_cnt_q    <= '0;
      game_reset_q  <= 1'b0;
      game_active_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      game_reset_q  <= game_reset_d;
      game_active_q <= game_active_d;
    end
  end

  // Next-state, hold countdown and next output values.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    game_reset_d = 1'b0;

    case (state_q)
      SCR_START: begin
        if (key_edge) begin
          state_d      = SCR_PLAY;
          game_reset_d = 1'b1;
        end
      end

      SCR_PLAY: begin
        if (red_hit && green_hit) begin
          // Draw: restart the round without leaving play.
          game_reset_d = 1'b1;
        end else if (green_hit) begin
          state_d    = SCR_RED_WIN;
          hold_cnt_d = HOLD_INIT;
        end else if (red_hit) begin
          state_d    = SCR_GREEN_WIN;
          hold_cnt_d = HOLD_INIT;
        end
      end

      SCR_RED_WIN, SCR_GREEN_WIN: begin
        // Presses during the hold are dropped, not remembered.
        if (key_edge && (hold_cnt_q == '0)) begin
          state_d = SCR_START;
        end else if (frame_tick && (hold_cnt_q != '0)) begin
          hold_cnt_d = hold_cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = SCR_START;
      end
    endcase

    game_active_d = (state_d == SCR_PLAY);
  end

  assign screen      = state_q;
  assign game_reset  = game_reset_q;
  assign game_active = game_active_q;

endmodule

// File: tb/tb_screen_fsm.sv
// Directed bench for screen_fsm with a short win hold of three frames.
module tb_screen_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       vs;
  logic [7:0] keycode;
  logic       red_hit;
  logic       green_hit;
  logic [1:0] screen;
  logic       game_reset;
  logic       game_active;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  screen_fsm #(.START_KEY(8'h28), .WIN_HOLD_FRAMES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .vs          (vs),
    .keycode     (keycode),
    .red_hit     (red_hit),
    .green_hit   (green_hit),
    .screen      (screen),
    .game_reset  (game_reset),
    .game_active (game_active)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] scr, input logic gr, input logic act);
    chk({tag, ".screen"},      {6'd0, screen},      {6'd0, scr});
    chk({tag, ".game_reset"},  {7'd0, game_reset},  {7'd0, gr});
    chk({tag, ".game_active"}, {7'd0, game_active}, {7'd0, act});
  endtask

  // One full vs low pulse; the falling edge is sampled on the first cycle.
  task automatic vs_tick();
    vs = 1'b0;
    cyc();
    vs = 1'b1;
    cyc();
  endtask

  initial begin
    reset = 1'b1; vs = 1'b1; keycode = 8'h00; red_hit = 1'b0; green_hit = 1'b0;
    cyc(); cyc();
    chk_out("reset", 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc();
    chk_out("idle_start", 2'b00, 1'b0, 1'b0);

    // Start key held for 3 cycles -> play, single restart pulse
    keycode = 8'h28;
    cyc(); chk_out("start_press", 2'b01, 1'b1, 1'b1);
    cyc(); chk_out("start_held1", 2'b01, 1'b0, 1'b1);
    cyc(); chk_out("start_held2", 2'b01, 1'b0, 1'b1);
    keycode = 8'h00;
    cyc(); chk_out("play_idle", 2'b01, 1'b0, 1'b1);

    // Green hit -> red wins, hold of 3 frames
    green_hit = 1'b1;
    cyc(); chk_out("red_win", 2'b10, 1'b0, 1'b0);
    green_hit = 1'b0;
    vs_tick(); vs_tick();
    keycode = 8'h28;
    cyc(); chk_out("press_in_hold", 2'b10, 1'b0, 1'b0);
    keycode = 8'h00;
    cyc();
    vs_tick(); vs_tick(); vs_tick();
    chk_out("hold_expired", 2'b10, 1'b0, 1'b0);
    keycode = 8'h28;
    cyc(); chk_out("win_to_start", 2'b00, 1'b0, 1'b0);
    keycode = 8'h00;
    cyc();

    // Draw then red hit -> green wins
    keycode = 8'h28;
    cyc(); chk_out("replay", 2'b01, 1'b1, 1'b1);
    keycode = 8'h00;
    cyc(); chk_out("replay_settle", 2'b01, 1'b0, 1'b1);
    red_hit = 1'b1; green_hit = 1'b1;
    cyc(); chk_out("draw", 2'b01, 1'b1, 1'b1);
    red_hit = 1'b0; green_hit = 1'b0;
    cyc(); chk_out("draw_after", 2'b01, 1'b0, 1'b1);
    red_hit = 1'b1;
    cyc(); chk_out("green_win", 2'b11, 1'b0, 1'b0);
    red_hit = 1'b0;

    // Reset mid-hold (hold_cnt=2)
    vs_tick();
    chk_out("mid_hold", 2'b11, 1'b0, 1'b0);
    reset = 1'b1;
    cyc(); chk_out("reset_mid_hold", 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(); chk_out("after_reset", 2'b00, 1'b0, 1'b0);

    // Key held continuously from start through hold expiry
    keycode = 8'h28;
    cyc(); chk_out("held_enter", 2'b01, 1'b1, 1'b1);
    cyc(); cyc(); chk_out("held_play", 2'b01, 1'b0, 1'b1);
    green_hit = 1'b1;
    cyc(); chk_out("held_red_win", 2'b10, 1'b0, 1'b0);
    green_hit = 1'b0;
    vs_tick(); vs_tick(); vs_tick(); vs_tick();
    cyc(); chk_out("held_after_hold", 2'b10, 1'b0, 1'b0);
    keycode = 8'h00;
    cyc(); chk_out("held_release", 2'b10, 1'b0, 1'b0);
    keycode = 8'h28;
    cyc(); chk_out("held_repress", 2'b00, 1'b0, 1'b0);
    keycode = 8'h00;
    cyc();

    // Wrong key and hits on the start screen
    keycode = 8'h29; red_hit = 1'b1; green_hit = 1'b1;
    cyc(); chk_out("start_noise1", 2'b00, 1'b0, 1'b0);
    red_hit = 1'b0;
    cyc(); chk_out("start_noise2", 2'b00, 1'b0, 1'b0);
    keycode = 8'h00; green_hit = 1'b0;
    cyc();

    // Key held through reset acts on the first cycle out of reset
    keycode = 8'h28; reset = 1'b1;
    cyc(); cyc(); chk_out("key_in_reset", 2'b00, 1'b0, 1'b0);
    reset = 1'b0;
    cyc(); chk_out("key_out_reset", 2'b01, 1'b1, 1'b1);
    keycode = 8'h00;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
